// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module  : rv32i_pkg
// Brief   : Shared load/store types for the RV32I data-memory path.
//           LSU_MISALIGN_SPLIT_EN adds the split-access states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam int DMEM_LINE_BYTES = 8;

  typedef enum logic [1:0] {
    LSU_BYTE    = 2'b00,
    LSU_HALF    = 2'b01,
    LSU_WORD    = 2'b10,
    LSU_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    WRITE   = 3'd2,
    RESP    = 3'd3
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    ACCESS2 = 3'd4,
    WRITE2  = 3'd5
`endif
  } lsu_state_e;

  function automatic logic [3:0] lsu_nbytes(input lsu_size_e size);
    case (size)
      LSU_BYTE: return 4'd1;
      LSU_HALF: return 4'd2;
      LSU_WORD: return 4'd4;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_byte_lane.sv
// ============================================================================
// Module  : lsu_byte_lane
// Brief   : Combinational load extract/extend and store byte merge over a
//           window of one or two memory lines.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_byte_lane
  import rv32i_pkg::*;
#(
  parameter int WIN_BYTES = DMEM_LINE_BYTES
) (
  input  logic [WIN_BYTES*8-1:0] win_i,
  input  logic [2:0]             off_i,
  input  lsu_size_e              size_i,
  input  logic                   unsigned_i,
  input  logic [31:0]            wdata_i,
  output logic [31:0]            ldata_o,
  output logic [WIN_BYTES*8-1:0] merged_o
);

  logic [WIN_BYTES*8-1:0] shifted;

  always_comb begin
    shifted = win_i >> {off_i, 3'b000};
    case (size_i)
      LSU_BYTE: ldata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      LSU_HALF: ldata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:  ldata_o = shifted[31:0];
    endcase
  end

  // Bytes outside the access keep the line contents read from memory.
  always_comb begin
    merged_o = win_i;
    for (int i = 0; i < 4; i++) begin
      if ((i < int'(lsu_nbytes(size_i))) && ((int'(off_i) + i) < WIN_BYTES)) begin
        merged_o[(int'(off_i) + i)*8 +: 8] = wdata_i[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu_ctrl.sv
// ============================================================================
// Module  : dmem_lsu_ctrl
// Brief   : RV32I load/store controller for a 64-bit line memory without byte
//           enables. Macro LSU_MISALIGN_SPLIT_EN enables line-crossing splits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_lsu_ctrl
  import rv32i_pkg::*;
#(
  parameter int MEM_SIZE  = 4096,
  parameter int MEM_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_fault,
  output logic [MEM_WIDTH-1:0] mem_rd_addr,
  input  logic [63:0]          mem_rd_data,
  output logic [MEM_WIDTH-1:0] mem_wr_addr,
  output logic [63:0]          mem_wr_data,
  output logic                 mem_wr_en
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int WIN_BYTES = 2*DMEM_LINE_BYTES;
`else
  localparam int WIN_BYTES = DMEM_LINE_BYTES;
`endif
  localparam int WIN_W = WIN_BYTES*8;

  lsu_state_e           state_q, state_d;
  lsu_size_e            size_q, size_d;
  logic                 we_q, we_d, uns_q, uns_d, fault_q, fault_d;
  logic [MEM_WIDTH-1:0] line_q, line_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [2:0]           off_q, off_d;
  logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
  logic [63:0]          wr_data_q, wr_data_d;

  logic [MEM_WIDTH-1:0] req_line;
  logic                 req_oor, req_fault;
  logic [WIN_W-1:0]     win, merged;
  logic [31:0]          ldata;

  assign req_line = req_addr[MEM_WIDTH+2:3];
  assign req_oor  = (req_addr >> (MEM_WIDTH+3)) != 32'd0;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        req_cross, cap_cross;
  logic [63:0] lo_q, lo_d, hi_q, hi_d;

  assign req_cross = ({1'b0, req_addr[2:0]} + lsu_nbytes(lsu_size_e'(req_size))) > 4'd8;
  assign cap_cross = ({1'b0, off_q} + lsu_nbytes(size_q)) > 4'd8;
  // A crossing access from the last line would need a line that does not exist.
  assign req_fault = req_oor || (req_size == 2'b11) ||
                     (req_cross && (req_line == MEM_WIDTH'(MEM_SIZE-1)));
  assign win       = (state_q == ACCESS2) ? {mem_rd_data, lo_q} : {64'd0, mem_rd_data};
`else
  assign req_fault = req_oor || (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign win       = mem_rd_data;
`endif

  lsu_byte_lane #(.WIN_BYTES(WIN_BYTES)) u_lane (
    .win_i      (win),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .ldata_o    (ldata),
    .merged_o   (merged)
  );

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    fault_d   = fault_q;
    line_d    = line_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    lo_d      = lo_q;
    hi_d      = hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = lsu_size_e'(req_size);
          we_d    = req_we;
          uns_d   = req_unsigned;
          line_d  = req_line;
          off_d   = req_addr[2:0];
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          fault_d = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else begin
            rd_addr_d = req_line;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (cap_cross) begin
          lo_d      = mem_rd_data;
          rd_addr_d = line_q + MEM_WIDTH'(1);
          state_d   = ACCESS2;
        end else
`endif
        if (we_q) begin
          wr_addr_d = line_q;
          wr_data_d = merged[63:0];
          state_d   = WRITE;
        end else begin
          rdata_d = ldata;
          state_d = RESP;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACCESS2: begin
        if (we_q) begin
          wr_addr_d = line_q;
          wr_data_d = merged[63:0];
          hi_d      = merged[127:64];
          state_d   = WRITE;
        end else begin
          rdata_d = ldata;
          state_d = RESP;
        end
      end
      WRITE: begin
        if (cap_cross) begin
          wr_addr_d = line_q + MEM_WIDTH'(1);
          wr_data_d = hi_q;
          state_d   = WRITE2;
        end else begin
          state_d = RESP;
        end
      end
      WRITE2: state_d = RESP;
`else
      WRITE: state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      size_q    <= LSU_BYTE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      fault_q   <= 1'b0;
      line_q    <= '0;
      off_q     <= 3'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= 64'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q      <= 64'd0;
      hi_q      <= 64'd0;
`endif
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      fault_q   <= fault_d;
      line_q    <= line_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q      <= lo_d;
      hi_q      <= hi_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_fault   = rsp_valid & fault_q;
  assign rsp_rdata   = rdata_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign mem_wr_en   = (state_q == WRITE) || (state_q == WRITE2);
`else
  assign mem_wr_en   = (state_q == WRITE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
// ============================================================================
// Module  : tb_dmem_lsu_ctrl
// Brief   : Self-checking bench for dmem_lsu_ctrl with a byte-addressed
//           reference memory; honours LSU_MISALIGN_SPLIT_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_lsu_ctrl;

  localparam int MEM_SIZE = 4096;
  localparam int MW       = 12;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aresetn;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_fault;
  logic [31:0]   rsp_rdata;
  logic [MW-1:0] mem_rd_addr, mem_wr_addr;
  logic [63:0]   mem_rd_data, mem_wr_data;
  logic          mem_wr_en;

  logic          bk_en;
  logic [MW-1:0] bk_addr;
  logic [63:0]   bk_data;

  logic [63:0] dut_mem [MEM_SIZE];
  logic [63:0] ref_mem [MEM_SIZE];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_en    (mem_wr_en)
  );

  assign mem_rd_data = dut_mem[mem_rd_addr];

  always @(posedge clk) begin
    if (bk_en) dut_mem[bk_addr] <= bk_data;
    else if (mem_wr_en) dut_mem[mem_wr_addr] <= mem_wr_data;
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int nb(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_cross(input logic [31:0] a, input logic [1:0] s);
    return (int'(a % 8) + nb(s)) > 8;
  endfunction

  function automatic bit m_fault(input logic [31:0] a, input logic [1:0] s);
    if (a >= 32'(MEM_SIZE*8)) return 1'b1;
    if (s == 2'd3) return 1'b1;
    if (SPLIT) return m_cross(a, s) && ((a >> 3) == 32'(MEM_SIZE-1));
    return (a % 32'(nb(s))) != 0;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    logic [63:0] l;
    l = ref_mem[(a >> 3) % MEM_SIZE];
    return l[int'(a % 8)*8 +: 8];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input bit u);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = nb(s);
    for (int i = 0; i < n; i++) v = v | (32'(rbyte(a + 32'(i))) << (8*i));
    if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
    logic [63:0] l;
    int idx;
    for (int i = 0; i < nb(s); i++) begin
      idx = int'(((a + 32'(i)) >> 3) % MEM_SIZE);
      l = ref_mem[idx];
      l[int'((a + 32'(i)) % 8)*8 +: 8] = wd[8*i +: 8];
      ref_mem[idx] = l;
    end
  endtask

  function automatic int m_lat(input logic [31:0] a, input logic [1:0] s, input bit we);
    if (m_fault(a, s)) return 1;
    if (SPLIT && m_cross(a, s)) return we ? 5 : 3;
    return we ? 3 : 2;
  endfunction

  // ---------------- drivers (no checking here) ----------------
  task automatic bk_write(input int l, input logic [63:0] d);
    @(negedge clk);
    bk_en = 1'b1; bk_addr = MW'(l); bk_data = d;
    ref_mem[l] = d;
    @(negedge clk);
    bk_en = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic flt,
                       output int nwr, output int wcyc, output logic [MW-1:0] wa,
                       output logic [63:0] wdv);
    lat = -1; rd = 32'd0; flt = 1'b0; nwr = 0; wcyc = -1; wa = '0; wdv = 64'd0;
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_wr_en) begin
        nwr++;
        if (nwr == 1) begin wcyc = k; wa = mem_wr_addr; wdv = mem_wr_data; end
      end
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; flt = rsp_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    aresetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    bk_en = 1'b0; bk_addr = '0; bk_data = 64'd0;
    for (int l = 0; l < 10; l++) bk_write(l, {$urandom, $urandom});
    bk_write(MEM_SIZE-2, {$urandom, $urandom});
    bk_write(MEM_SIZE-1, {$urandom, $urandom});
    checks++;
    if ({req_ready, rsp_valid, rsp_fault, mem_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: ready/valid/fault/wr_en=%b want 1000", {req_ready, rsp_valid, rsp_fault, mem_wr_en});
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data} !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data: rdata=%h rd_addr=%h wr_addr=%h wr_data=%h ready=%b want all 0, ready 1",
               rsp_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data, req_ready);
    end
  endtask

  task automatic test_directed;
    int lat, nwr, wcyc;
    logic [31:0] rd;
    logic flt;
    logic [MW-1:0] wa;
    logic [63:0] wdv;
    bk_write(1, 64'h8877665544332211);

    issue(1'b0, 2'd0, 1'b0, 32'h0F, 32'd0, lat, rd, flt, nwr, wcyc, wa, wdv);
    checks++;
    if (lat !== 2 || rd !== 32'hFFFFFF88 || flt !== 1'b0) begin
      errors++;
      $display("FAIL lb_sign: lat=%0d rdata=%h fault=%b want lat=2 rdata=ffffff88 fault=0", lat, rd, flt);
    end

    issue(1'b0, 2'd0, 1'b1, 32'h0F, 32'd0, lat, rd, flt, nwr, wcyc, wa, wdv);
    checks++;
    if (lat !== 2 || rd !== 32'h00000088 || flt !== 1'b0) begin
      errors++;
      $display("FAIL lbu: lat=%0d rdata=%h fault=%b want lat=2 rdata=00000088 fault=0", lat, rd, flt);
    end

    issue(1'b1, 2'd2, 1'b0, 32'h0C, 32'hDEADBEEF, lat, rd, flt, nwr, wcyc, wa, wdv);
    m_store(32'h0C, 2'd2, 32'hDEADBEEF);
    checks++;
    if (nwr !== 1 || wcyc !== 2 || wa !== MW'(1) || wdv !== 64'hDEADBEEF44332211 || lat !== 3 || rd !== 32'd0) begin
      errors++;
      $display("FAIL sw_write: nwr=%0d cyc=%0d addr=%h data=%h lat=%0d rdata=%h want 1/2/1/deadbeef44332211/3/0",
               nwr, wcyc, wa, wdv, lat, rd);
    end

    issue(1'b1, 2'd1, 1'b0, 32'h0A, 32'h1234ABCD, lat, rd, flt, nwr, wcyc, wa, wdv);
    m_store(32'h0A, 2'd1, 32'h1234ABCD);
    checks++;
    if (dut_mem[1] !== 64'hDEADBEEFABCD2211 || lat !== 3 || nwr !== 1) begin
      errors++;
      $display("FAIL sh_merge: line1=%h lat=%0d nwr=%0d want deadbeefabcd2211/3/1", dut_mem[1], lat, nwr);
    end

    issue(1'b0, 2'd1, 1'b0, 32'h0A, 32'd0, lat, rd, flt, nwr, wcyc, wa, wdv);
    checks++;
    if (rd !== 32'hFFFFABCD || lat !== 2 || flt !== 1'b0) begin
      errors++;
      $display("FAIL lh_sign: rdata=%h lat=%0d fault=%b want ffffabcd/2/0", rd, lat, flt);
    end
  endtask

  task automatic test_faults;
    logic [31:0] addrs [6] = '{32'h02, 32'h10, 32'h8000, 32'h8004, 32'h03, 32'hFFFF_FFF0};
    logic [1:0]  sizes [6] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0};
    bit          wes   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat, nwr, wcyc, elat, enwr;
    logic [31:0] rd, erd;
    logic flt, ef;
    logic [MW-1:0] wa;
    logic [63:0] wdv;
    for (int i = 0; i < 6; i++) begin
      ef   = m_fault(addrs[i], sizes[i]);
      elat = m_lat(addrs[i], sizes[i], wes[i]);
      erd  = (ef || wes[i]) ? 32'd0 : m_load(addrs[i], sizes[i], 1'b0);
      enwr = (!ef && wes[i]) ? ((SPLIT && m_cross(addrs[i], sizes[i])) ? 2 : 1) : 0;
      issue(wes[i], sizes[i], 1'b0, addrs[i], 32'hA5A5_5A5A, lat, rd, flt, nwr, wcyc, wa, wdv);
      if (!ef && wes[i]) m_store(addrs[i], sizes[i], 32'hA5A5_5A5A);
      checks++;
      if (flt !== ef || lat !== elat || nwr !== enwr || rd !== erd) begin
        errors++;
        $display("FAIL fault_case%0d: fault=%b lat=%0d nwr=%0d rdata=%h want %b/%0d/%0d/%h",
                 i, flt, lat, nwr, rd, ef, elat, enwr, erd);
      end
    end
  endtask

  task automatic test_random_back_to_back;
    int lat, nwr, wcyc, elat, enwr, l0, l1, r;
    logic [31:0] rd, erd, addr, wd;
    logic [1:0] sz;
    logic flt, ef;
    bit we, uns;
    logic [MW-1:0] wa;
    logic [63:0] wdv;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = 32'(MEM_SIZE*8 - 16) + ($urandom % 16);
      else if (r == 1) addr = 32'(MEM_SIZE*8) + ($urandom % 32'h10000);
      else             addr = $urandom_range(0, 63);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      we  = 1'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      ef   = m_fault(addr, sz);
      elat = m_lat(addr, sz, we);
      erd  = (ef || we) ? 32'd0 : m_load(addr, sz, uns);
      enwr = (!ef && we) ? ((SPLIT && m_cross(addr, sz)) ? 2 : 1) : 0;
      issue(we, sz, uns, addr, wd, lat, rd, flt, nwr, wcyc, wa, wdv);
      if (!ef && we) m_store(addr, sz, wd);
      checks++;
      if (flt !== ef || lat !== elat || nwr !== enwr || rd !== erd) begin
        errors++;
        $display("FAIL rand%0d: addr=%h sz=%0d we=%b uns=%b fault=%b lat=%0d nwr=%0d rdata=%h want %b/%0d/%0d/%h",
                 n, addr, sz, we, uns, flt, lat, nwr, rd, ef, elat, enwr, erd);
      end
      l0 = int'((addr >> 3) % MEM_SIZE);
      l1 = (l0 + 1) % MEM_SIZE;
      checks++;
      if (dut_mem[l0] !== ref_mem[l0] || dut_mem[l1] !== ref_mem[l1]) begin
        errors++;
        $display("FAIL rand_mem%0d: line%0d=%h line%0d=%h want %h %h",
                 n, l0, dut_mem[l0], l1, dut_mem[l1], ref_mem[l0], ref_mem[l1]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, nwr, wcyc;
    logic [31:0] rd;
    logic flt;
    logic [MW-1:0] wa;
    logic [63:0] wdv;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h18; req_wdata = ~ref_mem[3][31:0];
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_write: wr_en=%b want 1", mem_wr_en);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: wr_en=%b valid=%b ready=%b want 0/0/1", mem_wr_en, rsp_valid, req_ready);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | rsp_valid | mem_wr_en; end
    aresetn = 1'b1;
    repeat (3) begin @(negedge clk); seen = seen | rsp_valid | mem_wr_en; end
    checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1 || dut_mem[3] !== ref_mem[3]) begin
      errors++;
      $display("FAIL rst_after: spurious=%b ready=%b line3=%h want 0/1/%h", seen, req_ready, dut_mem[3], ref_mem[3]);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h18, 32'd0, lat, rd, flt, nwr, wcyc, wa, wdv);
    checks++;
    if (rd !== m_load(32'h18, 2'd2, 1'b0) || lat !== 2 || flt !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume: rdata=%h lat=%0d fault=%b want %h/2/0", rd, lat, flt, m_load(32'h18, 2'd2, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_faults();
    test_random_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store controller between the RV32I execute stage and the 64-bit data memory.
- The memory has an asynchronous read port, a synchronous full-width write port and no byte enables.
- The block converts byte/half/word loads and stores into full-line reads and read-modify-write sequences.
- It sign/zero-extends load data and reports misaligned, out-of-range and illegal-size accesses as faults.

Parameters:
- MEM_SIZE, 4096: number of 64-bit lines in data memory.
- MEM_WIDTH, $clog2(MEM_SIZE): line index width.

Ports:
- clk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extend (LBU/LHU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-justified
- rsp_valid  output  1  one-cycle completion pulse; no backpressure
- rsp_rdata  output  32  extended load data; 0 for stores and faults
- rsp_fault  output  1  access fault, qualified by rsp_valid
- mem_rd_addr  output  MEM_WIDTH  line index to memory read port
- mem_rd_data  input  64  asynchronous read data
- mem_wr_addr  output  MEM_WIDTH  line index to memory write port
- mem_wr_data  output  64  merged line
- mem_wr_en  output  1  write strobe

Behaviour:
- Reset values:
  - state IDLE; req_ready 1.
  - rsp_valid, rsp_fault, mem_wr_en 0.
  - rsp_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data all 0.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE.
  - An in-flight store whose WRITE state was not reached is dropped.
  - No response is issued for the aborted request.
- Address decode:
  - line = addr[MEM_WIDTH+2:3]; offset = addr[2:0].
  - addr[31:MEM_WIDTH+3] != 0 is an out-of-range fault.
- Faults: out-of-range, size 11, half with addr[0]=1, word with addr[1:0]!=0.
- States: IDLE, ACCESS, WRITE, RESP (plus ACCESS2/WRITE2 under the optional feature).
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted when req_valid & req_ready; all fields are captured at acceptance.
- Transitions:
  - IDLE → RESP on a faulting request; latency 1, rsp_fault=1, no memory write.
  - IDLE → ACCESS on any legal request.
  - ACCESS:
    - mem_rd_addr = captured line.
    - Load: register extracted, extended data; go to RESP.
    - Store: register merged line (replace size bytes at offset, others from mem_rd_data); go to WRITE.
  - WRITE: mem_wr_en=1 for exactly one cycle, mem_wr_addr = line, mem_wr_data = merged line; go to RESP.
  - RESP: rsp_valid=1 for one cycle; go to IDLE.
- Latency (acceptance to rsp_valid): load 2 cycles, store 3, fault 1.
- Extension:
  - Byte/half loads sign-extend bit 7/15 unless req_unsigned.
  - req_unsigned is ignored for word loads and for stores.
- Store data: only the low 8/16/32 bits of req_wdata are used.
- mem_rd_addr holds its last value outside ACCESS.
- mem_wr_en is driven from state decode only, never combinationally from request inputs.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned half/word accesses are legal.
  - Accesses fully inside one line complete in a single beat.
  - Accesses crossing a line boundary use ACCESS→ACCESS2 (line+1), then for stores WRITE→WRITE2.
  - Load latency 3; store latency 5.
  - A crossing access from the last line (line+1 == MEM_SIZE) faults.
- Undefined: misaligned accesses fault as listed in Behaviour; ACCESS2/WRITE2 are absent.

Decomposition:
- In rv32i_pkg:
  - lsu_size_e (LSU_BYTE=2'b00, LSU_HALF=2'b01, LSU_WORD=2'b10).
  - lsu_state_e.
  - localparam DMEM_LINE_BYTES=8.
- Sub-module lsu_byte_lane (combinational):
  - Extract/extend a load from a line.
  - Merge store bytes into a line, given offset and size.
  - Instantiated once; under the optional feature it takes a 128-bit two-line window.

Test Plan:
- Line 1 preloaded 0x8877665544332211; LB addr 0x0F → rsp_rdata 0xFFFFFF88 at acceptance+2, fault 0; LBU same address → 0x00000088.
- SW 0xDEADBEEF to 0x0C over line 1 above → exactly one mem_wr_en pulse at acceptance+2, wr_addr 1, wr_data 0xDEADBEEF44332211; rsp_valid at +3.
- SH 0xABCD to 0x0A, then LH 0x0A → line 1 bytes [3:2] = CD,AB (rest unchanged); load returns 0xFFFFABCD.
- LW 0x02 (feature off) → rsp_fault=1, rsp_valid at +1, no mem_wr_en; size 11 and addr 0x0000_8000 (MEM_SIZE=4096) → same.
- Feature on: SW 0x11223344 to 0x06 → two writes: line 0 bytes[7:6]=44,33 and line 1 bytes[1:0]=22,11; LW 0x06 returns 0x11223344.
- Assert aresetn low during WRITE of a store → mem_wr_en drops immediately, no rsp_valid, req_ready=1 after release; memory unchanged if the pulse was cut before the clock edge.
